// File: rtl/pkt_pkg.sv
// Shared types and default constants for the packet header filter.
package pkt_pkg;

    localparam int          PKT_DATA_W    = 32;
    localparam int          PKT_HDR_W     = 32;
    localparam int          PKT_CNT_W     = 16;
    localparam logic [31:0] PKT_STAMP_DEF = 32'h1010_1010;

    // IDLE: no packet open; PASS: forwarding open packet; DROP: discarding it
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } pkt_state_e;

endpackage

// File: rtl/pkt_interface.sv
// Packet stream bundle: reset, config, input beat and filtered output beat.
interface pkt_interface
    import pkt_pkg::*;
#(
    parameter int DATA_W = PKT_DATA_W,
    parameter int HDR_W  = PKT_HDR_W,
    parameter int CNT_W  = PKT_CNT_W
) (
    input logic clk
);
    logic              rst;
    logic [HDR_W-1:0]  cfg_match;
    logic [HDR_W-1:0]  cfg_mask;
    logic              cfg_invert;
    logic              cfg_stamp_en;
    logic [HDR_W-1:0]  hdr_in;
    logic              sop_in;
    logic              ena_in;
    logic [DATA_W-1:0] data0_in;
    logic              ena_out;
    logic              sop_out;
    logic [DATA_W-1:0] data0_out;
    logic [CNT_W-1:0]  pass_cnt;
    logic [CNT_W-1:0]  drop_cnt;

    // Packet driver side
    modport master (
        input  clk,
        output rst, cfg_match, cfg_mask, cfg_invert, cfg_stamp_en,
        output hdr_in, sop_in, ena_in, data0_in,
        input  ena_out, sop_out, data0_out, pass_cnt, drop_cnt
    );

    // Filter side
    modport slave (
        input  clk,
        input  rst, cfg_match, cfg_mask, cfg_invert, cfg_stamp_en,
        input  hdr_in, sop_in, ena_in, data0_in,
        output ena_out, sop_out, data0_out, pass_cnt, drop_cnt
    );
endinterface

// File: rtl/pkt_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module pkt_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q, cnt_d;

    // Next count: step only when asked and not already saturated
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/pkt_hdr_filter.sv
// Header filter: decides forward/drop on each sop beat, applies the decision
// to the whole packet, optionally stamps the first word, counts packets.
module pkt_hdr_filter
    import pkt_pkg::*;
#(
    parameter int               DATA_W = PKT_DATA_W,
    parameter int               HDR_W  = PKT_HDR_W,
    parameter int               CNT_W  = PKT_CNT_W,
    parameter logic [DATA_W-1:0] STAMP = DATA_W'(PKT_STAMP_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [HDR_W-1:0]  cfg_match,
    input  logic [HDR_W-1:0]  cfg_mask,
    input  logic              cfg_invert,
    input  logic              cfg_stamp_en,
    input  logic [HDR_W-1:0]  hdr_in,
    input  logic              sop_in,
    input  logic              ena_in,
    input  logic [DATA_W-1:0] data0_in,
    output logic              ena_out,
    output logic              sop_out,
    output logic [DATA_W-1:0] data0_out,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);
    pkt_state_e        state_q, state_d;
    logic              ena_out_q, ena_out_d;
    logic              sop_out_q, sop_out_d;
    logic [DATA_W-1:0] data0_out_q, data0_out_d;
    logic              hdr_hit, fwd;
    logic              pass_inc, drop_inc;

    // Config only matters on sop beats, so it is consumed only there
    assign hdr_hit = (((hdr_in ^ cfg_match) & cfg_mask) == '0);
    assign fwd     = hdr_hit ^ cfg_invert;

    // Next state and next output beat; data holds when nothing is forwarded
    always_comb begin
        state_d     = state_q;
        ena_out_d   = 1'b0;
        sop_out_d   = 1'b0;
        data0_out_d = data0_out_q;
        pass_inc    = 1'b0;
        drop_inc    = 1'b0;
        if (ena_in) begin
            if (sop_in) begin
                if (fwd) begin
                    state_d     = ST_PASS;
                    ena_out_d   = 1'b1;
                    sop_out_d   = 1'b1;
                    data0_out_d = cfg_stamp_en ? STAMP : data0_in;
                    pass_inc    = 1'b1;
                end else begin
                    state_d  = ST_DROP;
                    drop_inc = 1'b1;
                end
            end else if (state_q == ST_PASS) begin
                ena_out_d   = 1'b1;
                data0_out_d = data0_in;
            end
        end
    end

    // State and registered outputs; reset wins over any beat in that cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ena_out_q   <= 1'b0;
            sop_out_q   <= 1'b0;
            data0_out_q <= '0;
        end else begin
            state_q     <= state_d;
            ena_out_q   <= ena_out_d;
            sop_out_q   <= sop_out_d;
            data0_out_q <= data0_out_d;
        end
    end

    pkt_sat_counter #(.W(CNT_W)) u_pass_cnt (
        .clk (clk),
        .rst (rst),
        .inc (pass_inc),
        .cnt (pass_cnt)
    );

    pkt_sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk (clk),
        .rst (rst),
        .inc (drop_inc),
        .cnt (drop_cnt)
    );

    assign ena_out   = ena_out_q;
    assign sop_out   = sop_out_q;
    assign data0_out = data0_out_q;
endmodule

// File: doc/pkt_hdr_filter.md
# pkt_hdr_filter

Parametrised packet header filter on the packet stream. Examines the header presented on each start-of-packet beat, compares it against a programmable match value/mask, and forwards or discards the whole packet. Optionally overwrites the first data word of forwarded packets with a stamp value. Keeps saturating pass/drop packet counters. Sits between the packet driver side and downstream packet consumers, as the generalised replacement for the fixed-constant device stage.

## Interface

Parameters:

- DATA_W, 32, data bus width.
- HDR_W, 32, header width.
- CNT_W, 16, packet counter width.
- STAMP, 32'h10101010 (resized to DATA_W), value written by stamp mode.

Ports:

- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- cfg_match  input  HDR_W  header compare value.
- cfg_mask  input  HDR_W  compare mask; 1 = bit compared.
- cfg_invert  input  1  0: forward matching packets; 1: forward non-matching packets.
- cfg_stamp_en  input  1  1: replace first data word of forwarded packets with STAMP.
- hdr_in  input  HDR_W  header, valid only when sop_in & ena_in.
- sop_in  input  1  start-of-packet; meaningful only with ena_in.
- ena_in  input  1  beat valid.
- data0_in  input  DATA_W  beat data.
- ena_out  output  1  output beat valid.
- sop_out  output  1  output start-of-packet.
- data0_out  output  DATA_W  output data.
- pass_cnt  output  CNT_W  forwarded packet count.
- drop_cnt  output  CNT_W  dropped packet count.

## Operation

- Packet = beat with ena_in&sop_in plus all following ena_in beats until the next sop beat. There is no end marker and no backpressure.
- Match: ((hdr_in ^ cfg_match) & cfg_mask) == 0. Forward = match XOR cfg_invert. This is evaluated only on the sop beat.
- The forward decision is latched in a keep flag, which applies to the sop beat and every following beat of that packet.
- States: IDLE (no packet open, keep=0), PASS, DROP.
  - Any state on an sop beat: PASS if forward, else DROP.
  - A non-sop beat in IDLE is discarded and not counted.
  - Back-to-back sop beats are legal; each is a one-beat packet decided independently.
- Forwarded beat outputs: ena_out=1, sop_out=sop_in, data0_out=data0_in. The exception is the sop beat when cfg_stamp_en=1, where data0_out=STAMP.
- Dropped or idle cycles: ena_out=0, sop_out=0, and data0_out holds its last value.
- Counters count packets, not beats:
  - pass_cnt increments on each forwarded sop beat; drop_cnt increments on each dropped sop beat.
  - Both saturate at all-ones (no wrap).
- cfg_* inputs are sampled only on sop beats. Changing them mid-packet does not affect the open packet.
- Reset mid-packet: the state returns to IDLE. The remaining beats of that packet are discarded until the next sop.

## Timing

- Latency is 1 cycle: an input beat at edge N appears on the outputs after edge N. The output is fully registered.
- Throughput: one beat per cycle, sustained indefinitely.
- Counter update is visible 1 cycle after the sop beat, aligned with sop_out.
- Reset values: ena_out=0, sop_out=0, data0_out=0, pass_cnt=0, drop_cnt=0, state=IDLE.
- An input beat present in the same cycle rst is asserted is ignored.

## Structure

- Package pkt_pkg holds:
  - typedef enum for states IDLE/PASS/DROP;
  - default width constants (PKT_DATA_W, PKT_HDR_W);
  - default stamp constant PKT_STAMP_DEF.
- Sub-module pkt_sat_counter: parameter W; ports clk, rst, inc, cnt. It increments and saturates, and is instantiated twice.
- The pkt_interface bundle gains a rst signal. A wrapper may bind the ports to the interface; the core stays on plain ports.

## Test plan

- Reset, then mask=all-ones, match=32'hCAFE0001, invert=0. Send sop beat with hdr 32'hCAFE0001 plus 3 beats, data 1..4 → four output beats one cycle later; sop_out on the first; data 1..4; pass_cnt=1.
- Same config, hdr 32'hCAFE0002 → no ena_out for any of its 4 beats; drop_cnt=1. Repeat with invert=1 → packet forwarded, pass_cnt increments.
- mask=32'hFFFF0000, stamp_en=1, hdr 32'hCAFE1234, data 7,8 → outputs 32'h10101010, 8.
- Back-to-back sop beats alternating match and mismatch for 6 cycles → only matching beats are output; pass_cnt=3, drop_cnt=3.
- CNT_W=4; send 20 matching packets → pass_cnt sticks at 15.
- Assert rst for 1 cycle mid-packet (after beat 2 of 5) → outputs go to 0; beats 3–5 are not forwarded; counters read 0; the next sop packet is forwarded normally.
